// File: rtl/mdu_ctrl.sv
// mdu_ctrl: HI/LO multiply-unit controller.
// Decodes MULT/MULTU/MFHI/MFLO/MTHI/MTLO, sequences the external multiplier
// through a begin/end handshake, owns HI/LO and stalls EX while a product is
// outstanding. A watchdog aborts a multiply that never reports completion.
module mdu_ctrl #(
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_src1,
  input  logic [31:0] op_src2,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] read_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        mdu_error,
  output logic        mult_begin,
  output logic [31:0] mult_op1,
  output logic [31:0] mult_op2,
  output logic        mult_sign,
  input  logic [63:0] product,
  input  logic        mult_end
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_MFHI  = 3'd3;
  localparam logic [2:0] OP_MFLO  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;

  logic is_mul;
  logic is_hilo;
  logic accept;
  logic wd_hit;
  logic busy_done;
  logic mt_wr;

  assign is_mul    = (op_code == OP_MULT) || (op_code == OP_MULTU);
  assign is_hilo   = (op_code != 3'd0) && (op_code != 3'd7);
  assign accept    = (state == IDLE) && op_valid && is_mul && !flush;
  // The watchdog only fires when the multiplier stays silent; a completion
  // landing on the last allowed cycle still counts as a normal finish.
  assign wd_hit    = (state == BUSY) && !mult_end && (wait_cnt == 8'(MAX_WAIT - 1));
  assign busy_done = (state == BUSY) && (mult_end || flush || wd_hit);
  assign mt_wr     = op_valid && !stall && !flush &&
                     ((op_code == OP_MTHI) || (op_code == OP_MTLO));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: DRAIN is a single mandatory cycle with begin low
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = BUSY;
      BUSY:    if (busy_done) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: pipeline hold and HI/LO read mux
  always_comb begin
    stall     = 1'b0;
    read_data = 32'd0;
    case (state)
      IDLE:    stall = accept;
      BUSY:    stall = !busy_done;
      DRAIN:   stall = op_valid && is_hilo && !flush;
      default: stall = 1'b0;
    endcase
    if (op_valid && op_code == OP_MFHI) read_data = hi;
    if (op_valid && op_code == OP_MFLO) read_data = lo;
  end

  // Multiplier handshake, operand capture and watchdog counter
  always_ff @(posedge clk) begin
    if (rst) begin
      mult_begin <= 1'b0;
      mult_op1   <= 32'd0;
      mult_op2   <= 32'd0;
      mult_sign  <= 1'b0;
      wait_cnt   <= 8'd0;
    end else if (accept) begin
      mult_begin <= 1'b1;
      mult_op1   <= op_src1;
      mult_op2   <= op_src2;
      mult_sign  <= (op_code == OP_MULT);
      wait_cnt   <= 8'd0;
    end else if (busy_done) begin
      mult_begin <= 1'b0;
    end else if (state == BUSY) begin
      wait_cnt   <= wait_cnt + 8'd1;
    end
  end

  // Architectural HI/LO: product write on clean completion, else MTHI/MTLO
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (state == BUSY && mult_end && !flush) begin
      hi <= product[63:32];
      lo <= product[31:0];
    end else if (mt_wr) begin
      if (op_code == OP_MTHI) hi <= op_src1;
      else                    lo <= op_src1;
    end
  end

  // Sticky watchdog flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst)         mdu_error <= 1'b0;
    else if (wd_hit) mdu_error <= 1'b1;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scenario tasks plus a randomized run checked against a
// behavioural HI/LO/error model that uses plain 64-bit arithmetic.
module tb_mdu_ctrl;

  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op_code = 3'd0;
  logic [31:0] op_src1 = 32'd0;
  logic [31:0] op_src2 = 32'd0;
  logic        flush = 1'b0;
  logic        stall;
  logic [31:0] read_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        mdu_error;
  logic        mult_begin;
  logic [31:0] mult_op1;
  logic [31:0] mult_op2;
  logic        mult_sign;
  logic [63:0] product = 64'd0;
  logic        mult_end = 1'b0;

  int passed = 0;
  int total  = 0;

  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;
  logic        exp_err = 1'b0;

  mdu_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .op_src1(op_src1), .op_src2(op_src2), .flush(flush), .stall(stall),
    .read_data(read_data), .hi(hi), .lo(lo), .mdu_error(mdu_error),
    .mult_begin(mult_begin), .mult_op1(mult_op1), .mult_op2(mult_op2),
    .mult_sign(mult_sign), .product(product), .mult_end(mult_end)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_prod(input logic [2:0] code, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = (code == 3'd1) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (code == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  // Drive one multiply from the accept cycle until EX is released.
  // Cycle c=lat carries mult_end (unless never_end); cycle c=flush_at carries flush.
  task automatic run_mult(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int flush_at, input bit never_end,
                          output int scyc, output bit ops_ok, output bit done);
    logic [63:0] p;
    logic s;
    p = ref_prod(code, a, b);
    scyc = 0; ops_ok = 1'b1; done = 1'b0;
    op_valid = 1'b1; op_code = code; op_src1 = a; op_src2 = b;
    for (int c = 0; c < 64; c++) begin
      mult_end = !never_end && (c == lat);
      product  = (c == lat) ? p : {$urandom, $urandom};
      flush    = (c == flush_at);
      @(negedge clk);
      if (c >= 1 && (mult_op1 !== a || mult_op2 !== b ||
                     mult_sign !== (code == 3'd1) || mult_begin !== 1'b1)) ops_ok = 1'b0;
      s = stall;
      if (s) scyc++;
      @(posedge clk); #1;
      if (!s) begin
        done = 1'b1;
        break;
      end
    end
    op_valid = 1'b0; op_code = 3'd0; mult_end = 1'b0; flush = 1'b0;
  endtask

  // Present one single-cycle instruction and sample stall/read_data.
  task automatic one_op(input logic [2:0] code, input logic [31:0] val, input bit fl,
                        output logic s, output logic [31:0] rd);
    op_valid = 1'b1; op_code = code; op_src1 = val; op_src2 = $urandom; flush = fl;
    @(negedge clk);
    s = stall; rd = read_data;
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'd0; flush = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    op_valid = 1'b1; op_code = 3'd3;
    @(negedge clk);
    total++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else passed++;
    total++; if (mult_begin !== 1'b0) $display("FAIL reset_begin got %b want 0", mult_begin); else passed++;
    total++; if ({hi, lo} !== 64'd0) $display("FAIL reset_hilo got %h want 0", {hi, lo}); else passed++;
    total++; if (mdu_error !== 1'b0) $display("FAIL reset_err got %b want 0", mdu_error); else passed++;
    total++; if ({mult_op1, mult_op2, mult_sign} !== 65'd0)
      $display("FAIL reset_ops got %h want 0", {mult_op1, mult_op2, mult_sign}); else passed++;
    total++; if (read_data !== 32'd0) $display("FAIL reset_rd got %h want 0", read_data); else passed++;
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'd0;
    exp_hi = 0; exp_lo = 0; exp_err = 0;
  endtask

  task automatic test_mult_signed();
    int sc; bit ok; bit dn;
    run_mult(3'd1, 32'hFFFFFFFD, 32'd5, 3, 99, 1'b0, sc, ok, dn);
    total++; if (!dn) $display("FAIL mult_timeout got %0d want done", sc); else passed++;
    total++; if (sc !== 3) $display("FAIL mult_stall_cycles got %0d want 3", sc); else passed++;
    total++; if (!ok) $display("FAIL mult_ops_sign got unstable want stable"); else passed++;
    total++; if (hi !== 32'hFFFFFFFF) $display("FAIL mult_hi got %h want ffffffff", hi); else passed++;
    total++; if (lo !== 32'hFFFFFFF1) $display("FAIL mult_lo got %h want fffffff1", lo); else passed++;
    @(negedge clk);
    total++; if (mult_begin !== 1'b0) $display("FAIL drain_begin got %b want 0", mult_begin); else passed++;
    exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFF1;
    idle_cycle();
  endtask

  task automatic test_multu();
    int sc; bit ok; bit dn; int lat;
    lat = $urandom_range(1, 6);
    run_mult(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, 99, 1'b0, sc, ok, dn);
    total++; if (!dn || sc !== lat) $display("FAIL multu_stall got %0d want %0d", sc, lat); else passed++;
    total++; if (!ok) $display("FAIL multu_ops got unstable want stable"); else passed++;
    total++; if ({hi, lo} !== 64'hFFFFFFFE_00000001)
      $display("FAIL multu_hilo got %h want fffffffe00000001", {hi, lo}); else passed++;
    exp_hi = 32'hFFFFFFFE; exp_lo = 32'h00000001;
    idle_cycle();
  endtask

  task automatic test_mthi_mfhi();
    logic s; logic [31:0] rd; logic [31:0] v;
    one_op(3'd5, 32'hCAFEBABE, 1'b0, s, rd);
    total++; if (s !== 1'b0) $display("FAIL mthi_stall got %b want 0", s); else passed++;
    one_op(3'd3, 32'd0, 1'b0, s, rd);
    total++; if (s !== 1'b0 || rd !== 32'hCAFEBABE)
      $display("FAIL mfhi_after_mthi got %b/%h want 0/cafebabe", s, rd); else passed++;
    v = $urandom;
    one_op(3'd6, v, 1'b0, s, rd);
    one_op(3'd4, 32'd0, 1'b0, s, rd);
    total++; if (s !== 1'b0 || rd !== v) $display("FAIL mflo_after_mtlo got %b/%h want 0/%h", s, rd, v); else passed++;
    exp_hi = 32'hCAFEBABE; exp_lo = v;
  endtask

  task automatic test_flush();
    int sc; bit ok; bit dn; logic s; logic [31:0] rd;
    one_op(3'd5, 32'h11111111, 1'b0, s, rd);
    one_op(3'd6, 32'h22222222, 1'b0, s, rd);
    run_mult(3'd1, $urandom, $urandom, 2, 2, 1'b0, sc, ok, dn);
    total++; if (!dn || sc !== 2) $display("FAIL flush_stall got %0d want 2", sc); else passed++;
    total++; if ({hi, lo} !== 64'h11111111_22222222)
      $display("FAIL flush_hilo got %h want 1111111122222222", {hi, lo}); else passed++;
    one_op(3'd3, 32'd0, 1'b0, s, rd);
    total++; if (s !== 1'b1) $display("FAIL flush_drain_stall got %b want 1", s); else passed++;
    one_op(3'd3, 32'd0, 1'b0, s, rd);
    total++; if (s !== 1'b0 || rd !== 32'h11111111)
      $display("FAIL flush_mfhi got %b/%h want 0/11111111", s, rd); else passed++;
    exp_hi = 32'h11111111; exp_lo = 32'h22222222;
  endtask

  task automatic test_watchdog();
    int sc; bit ok; bit dn; logic [31:0] a; logic [31:0] b; logic [63:0] p;
    total++; if (mdu_error !== 1'b0) $display("FAIL wd_pre_err got %b want 0", mdu_error); else passed++;
    run_mult(3'd2, $urandom, $urandom, 99, 99, 1'b1, sc, ok, dn);
    total++; if (!dn || sc !== MAX_WAIT) $display("FAIL wd_stall got %0d want %0d", sc, MAX_WAIT); else passed++;
    total++; if (mdu_error !== 1'b1) $display("FAIL wd_err got %b want 1", mdu_error); else passed++;
    total++; if ({hi, lo} !== {exp_hi, exp_lo})
      $display("FAIL wd_hilo got %h want %h", {hi, lo}, {exp_hi, exp_lo}); else passed++;
    exp_err = 1'b1;
    idle_cycle();
    a = $urandom; b = $urandom; p = ref_prod(3'd1, a, b);
    run_mult(3'd1, a, b, 2, 99, 1'b0, sc, ok, dn);
    total++; if ({hi, lo} !== p) $display("FAIL wd_next_hilo got %h want %h", {hi, lo}, p); else passed++;
    total++; if (mdu_error !== 1'b1) $display("FAIL wd_sticky got %b want 1", mdu_error); else passed++;
    exp_hi = p[63:32]; exp_lo = p[31:0];
    idle_cycle();
  endtask

  task automatic test_mult_mfhi();
    int sc; bit ok; bit dn; logic s; logic [31:0] rd; logic [31:0] a; logic [31:0] b; logic [63:0] p;
    a = $urandom; b = $urandom; p = ref_prod(3'd2, a, b);
    run_mult(3'd2, a, b, $urandom_range(1, 5), 99, 1'b0, sc, ok, dn);
    one_op(3'd3, 32'd0, 1'b0, s, rd);
    total++; if (s !== 1'b1) $display("FAIL mfhi_drain_stall got %b want 1", s); else passed++;
    one_op(3'd3, 32'd0, 1'b0, s, rd);
    total++; if (s !== 1'b0 || rd !== p[63:32])
      $display("FAIL mfhi_new_hi got %b/%h want 0/%h", s, rd, p[63:32]); else passed++;
    exp_hi = p[63:32]; exp_lo = p[31:0];
  endtask

  task automatic test_noop();
    logic s; logic [31:0] rd;
    one_op(3'd0, $urandom, 1'b0, s, rd);
    total++; if (s !== 1'b0 || rd !== 32'd0) $display("FAIL noop0 got %b/%h want 0/0", s, rd); else passed++;
    one_op(3'd7, $urandom, 1'b0, s, rd);
    total++; if (s !== 1'b0 || rd !== 32'd0) $display("FAIL noop7 got %b/%h want 0/0", s, rd); else passed++;
    one_op(3'd1, $urandom, 1'b1, s, rd);
    @(negedge clk);
    total++; if (s !== 1'b0 || mult_begin !== 1'b0)
      $display("FAIL flushed_mult got %b/%b want 0/0", s, mult_begin); else passed++;
    idle_cycle();
  endtask

  task automatic test_reset_busy();
    logic s; logic [31:0] rd;
    one_op(3'd5, 32'hA5A5A5A5, 1'b0, s, rd);
    one_op(3'd6, 32'h5A5A5A5A, 1'b0, s, rd);
    op_valid = 1'b1; op_code = 3'd1; op_src1 = $urandom; op_src2 = $urandom;
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'd0; rst = 1'b1;
    @(negedge clk);
    total++; if (mult_begin !== 1'b1 || stall !== 1'b1)
      $display("FAIL rstbusy_pre got %b/%b want 1/1", mult_begin, stall); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (mult_begin !== 1'b0 || stall !== 1'b0 || {hi, lo} !== 64'd0)
      $display("FAIL rstbusy_post got %b/%b/%h want 0/0/0", mult_begin, stall, {hi, lo}); else passed++;
    @(posedge clk); #1;
    mult_end = 1'b1; product = {$urandom, $urandom};
    @(posedge clk); #1;
    mult_end = 1'b0;
    @(negedge clk);
    total++; if ({hi, lo} !== 64'd0 || mult_begin !== 1'b0 || mdu_error !== 1'b0)
      $display("FAIL late_end got %h/%b/%b want 0/0/0", {hi, lo}, mult_begin, mdu_error); else passed++;
    exp_hi = 0; exp_lo = 0; exp_err = 0;
    idle_cycle();
  endtask

  task automatic test_random();
    int sc; bit ok; bit dn; int lat; int fl; int endc; logic s; logic [31:0] rd;
    logic [2:0] k; logic [31:0] a; logic [31:0] b; logic [63:0] p; bit f;
    for (int i = 0; i < 40; i++) begin
      k = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      if (k == 3'd1 || k == 3'd2) begin
        lat  = $urandom_range(1, 10);
        fl   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 99;
        endc = lat;
        if (fl < endc) endc = fl;
        if (MAX_WAIT < endc) endc = MAX_WAIT;
        p = ref_prod(k, a, b);
        run_mult(k, a, b, lat, fl, 1'b0, sc, ok, dn);
        if (lat > MAX_WAIT && endc == MAX_WAIT) exp_err = 1'b1;
        if (endc == lat && fl != lat) begin
          exp_hi = p[63:32]; exp_lo = p[31:0];
        end
        total++; if (!dn || sc !== endc) $display("FAIL rnd%0d_stall got %0d want %0d", i, sc, endc); else passed++;
        total++; if (!ok) $display("FAIL rnd%0d_ops got unstable want stable", i); else passed++;
        total++; if ({hi, lo} !== {exp_hi, exp_lo})
          $display("FAIL rnd%0d_hilo got %h want %h", i, {hi, lo}, {exp_hi, exp_lo}); else passed++;
        total++; if (mdu_error !== exp_err)
          $display("FAIL rnd%0d_err got %b want %b", i, mdu_error, exp_err); else passed++;
        idle_cycle();
      end else begin
        f = ($urandom_range(0, 3) == 0);
        one_op(k, a, f, s, rd);
        if (!f && k == 3'd5) exp_hi = a;
        if (!f && k == 3'd6) exp_lo = a;
        total++; if (s !== 1'b0) $display("FAIL rnd%0d_op_stall got %b want 0", i, s); else passed++;
        if (k == 3'd3 || k == 3'd4) begin
          total++; if (rd !== ((k == 3'd3) ? exp_hi : exp_lo))
            $display("FAIL rnd%0d_mf got %h want %h", i, rd, (k == 3'd3) ? exp_hi : exp_lo); else passed++;
        end else begin
          total++; if ({hi, lo} !== {exp_hi, exp_lo})
            $display("FAIL rnd%0d_mt got %h want %h", i, {hi, lo}, {exp_hi, exp_lo}); else passed++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult_signed();
    test_multu();
    test_mthi_mfhi();
    test_flush();
    test_watchdog();
    test_mult_mfhi();
    test_noop();
    test_reset_busy();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
